// File: rtl/ibex_axi_pkg.sv
// Shared types for the Ibex memory-side arbiter: request source identifiers
// and the default depth of the outstanding-transaction tracker.
package ibex_axi_pkg;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } src_e;

  localparam int unsigned MaxOutstandingDefault = 2;

endpackage

// File: rtl/ibex_arb_id_fifo.sv
// One-bit-wide synchronous FIFO holding the source of every granted transfer
// so in-order responses can be steered back to the requester that issued them.
module ibex_arb_id_fifo
  import ibex_axi_pkg::*;
#(
  parameter int unsigned Depth = MaxOutstandingDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  src_e din_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output src_e head_o
);

  // A depth of one still needs a one-bit pointer that never leaves zero.
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  src_e            mem_q [Depth];
  src_e            mem_d [Depth];
  logic            do_push;
  logic            do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    ptr_inc = (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset: entries are only read once the count says valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Round-robin two-into-one arbiter merging Ibex fetch and data ports onto a
// single memory port, with request locking and in-order response routing.
module ibex_mem_arbiter
  import ibex_axi_pkg::*;
#(
  parameter int unsigned MaxOutstanding = MaxOutstandingDefault,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   instr_req_i,
  output logic                   instr_gnt_o,
  input  logic [AddrWidth-1:0]   instr_addr_i,
  output logic                   instr_rvalid_o,
  output logic [DataWidth-1:0]   instr_rdata_o,
  output logic                   instr_err_o,
  input  logic                   data_req_i,
  output logic                   data_gnt_o,
  input  logic                   data_we_i,
  input  logic [DataWidth/8-1:0] data_be_i,
  input  logic [AddrWidth-1:0]   data_addr_i,
  input  logic [DataWidth-1:0]   data_wdata_i,
  output logic                   data_rvalid_o,
  output logic [DataWidth-1:0]   data_rdata_o,
  output logic                   data_err_o,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic                   mem_rsp_valid_i,
  input  logic [DataWidth-1:0]   mem_rsp_rdata_i,
  input  logic                   mem_rsp_error_i,
  output logic                   unexp_rsp_o
);

  src_e last_src_q, last_src_d;
  src_e locked_src_q, locked_src_d;
  logic locked_q, locked_d;
  logic unexp_q, unexp_d;
  src_e sel;
  logic req;
  logic instr_elig, data_elig;
  logic push, pop;
  logic fifo_full, fifo_empty;
  src_e fifo_head;

  // Selection depends only on requests and registered state, never on mem_gnt_i.
  always_comb begin
    instr_elig = instr_req_i & ~fifo_full;
    data_elig  = data_req_i & ~fifo_full;
    sel        = SRC_INSTR;
    req        = 1'b0;
    if (locked_q) begin
      sel = locked_src_q;
      req = (locked_src_q == SRC_DATA) ? data_elig : instr_elig;
    end else if (instr_elig && data_elig) begin
      sel = (last_src_q == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
      req = 1'b1;
    end else if (data_elig) begin
      sel = SRC_DATA;
      req = 1'b1;
    end else if (instr_elig) begin
      sel = SRC_INSTR;
      req = 1'b1;
    end
  end

  assign mem_req_o   = req & ~rst_i;
  assign mem_addr_o  = (sel == SRC_DATA) ? data_addr_i : instr_addr_i;
  assign mem_we_o    = (sel == SRC_DATA) ? data_we_i : 1'b0;
  assign mem_be_o    = (sel == SRC_DATA) ? data_be_i : '1;
  assign mem_wdata_o = (sel == SRC_DATA) ? data_wdata_i : '0;

  assign push        = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = push & (sel == SRC_INSTR);
  assign data_gnt_o  = push & (sel == SRC_DATA);

  assign pop            = mem_rsp_valid_i & ~fifo_empty & ~rst_i;
  assign instr_rvalid_o = pop & (fifo_head == SRC_INSTR);
  assign data_rvalid_o  = pop & (fifo_head == SRC_DATA);
  assign instr_rdata_o  = mem_rsp_rdata_i;
  assign data_rdata_o   = mem_rsp_rdata_i;
  assign instr_err_o    = mem_rsp_error_i;
  assign data_err_o     = mem_rsp_error_i;
  assign unexp_rsp_o    = unexp_q;

  always_comb begin
    locked_d     = mem_req_o & ~mem_gnt_i;
    locked_src_d = locked_d ? sel : locked_src_q;
    last_src_d   = push ? sel : last_src_q;
    unexp_d      = unexp_q | (mem_rsp_valid_i & fifo_empty);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_src_q   <= SRC_INSTR;
      locked_src_q <= SRC_INSTR;
      locked_q     <= 1'b0;
      unexp_q      <= 1'b0;
    end else begin
      last_src_q   <= last_src_d;
      locked_src_q <= locked_src_d;
      locked_q     <= locked_d;
      unexp_q      <= unexp_d;
    end
  end

  ibex_arb_id_fifo #(
    .Depth(MaxOutstanding)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .din_i  (sel),
    .pop_i  (pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (fifo_head)
  );

endmodule
